// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter: widths, channel id, queued entry.
// Optional forwarding lookup is enabled by defining WB_FWD_EN.
package regwb_pkg;
  localparam int REG_AW = 6;
  localparam int REG_DW = 32;

  typedef enum logic {
    CH_A = 1'b0,
    CH_B = 1'b1
  } chan_e;

  typedef struct packed {
    logic [0:REG_AW-1] rw;
    logic [0:REG_DW-1] din;
  } entry_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the two write producers, the arbiter and the register file port.
// Forwarding signals exist only when WB_FWD_EN is defined.
interface regfile_wb_arbiter_if #(
  parameter int AW = 6,
  parameter int DW = 32
);
  // Handshake: a request transfers at a rising clk edge where x_valid && x_ready are both
  // high; x_ready never depends on x_valid, and the master holds x_rw/x_din while waiting.
  logic          a_valid;
  logic          a_ready;
  logic [0:AW-1] a_rw;
  logic [0:DW-1] a_din;
  logic          b_valid;
  logic          b_ready;
  logic [0:AW-1] b_rw;
  logic [0:DW-1] b_din;
  logic          wb_we;
  logic [0:AW-1] wb_rw;
  logic [0:DW-1] wb_din;
  logic          idle;
`ifdef WB_FWD_EN
  logic [0:AW-1] fwd_ra;
  logic          fwd_hit;
  logic [0:DW-1] fwd_data;
`endif

  modport master (
    output a_valid, a_rw, a_din, b_valid, b_rw, b_din,
    input  a_ready, b_ready, wb_we, wb_rw, wb_din, idle
`ifdef WB_FWD_EN
    , output fwd_ra
    , input  fwd_hit, fwd_data
`endif
  );

  modport slave (
    input  a_valid, a_rw, a_din, b_valid, b_rw, b_din,
    output a_ready, b_ready, wb_we, wb_rw, wb_din, idle
`ifdef WB_FWD_EN
    , input  fwd_ra
    , output fwd_hit, fwd_data
`endif
  );
endinterface

// File: rtl/regfile_wb_arbiter_fifo.sv
// DEPTH-entry synchronous FIFO with async reset; pushes when full and pops when empty are ignored.
// With WB_FWD_EN it also exposes its contents ordered oldest (index 0) to newest.
module wb_fifo
  import regwb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output entry_t        head
`ifdef WB_FWD_EN
  , output entry_t      entries [DEPTH]
`endif
);
  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

`ifdef WB_FWD_EN
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries[i] = mem[rd_ptr + PW'(i)];
    end
  end
`endif
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU (A) and load/multicycle (B) register writes into one registered write port.
// Define WB_FWD_EN to add the fwd_ra/fwd_hit/fwd_data pending-write lookup.
module regfile_wb_arbiter
  import regwb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW
) (
  input logic clk,
  input logic reset,
  regfile_wb_arbiter_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  entry_t        a_in, b_in, a_head, b_head;
  logic          a_full, a_empty, b_full, b_empty;
  logic [CW-1:0] a_count, b_count;
  logic          a_push, b_push;
  logic          grant_a, grant_b;
  chan_e         rr_last;
  logic          wb_we_q;
  logic [0:AW-1] wb_rw_q;
  logic [0:DW-1] wb_din_q;
`ifdef WB_FWD_EN
  entry_t        a_ent [DEPTH];
  entry_t        b_ent [DEPTH];
`endif

  assign bus.a_ready = !reset && !a_full;
  assign bus.b_ready = !reset && !b_full;
  assign a_push      = bus.a_valid && bus.a_ready;
  assign b_push      = bus.b_valid && bus.b_ready;
  assign a_in        = '{rw: bus.a_rw, din: bus.a_din};
  assign b_in        = '{rw: bus.b_rw, din: bus.b_din};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo_a (
    .clk       (clk),
    .reset     (reset),
    .push      (a_push),
    .push_data (a_in),
    .pop       (grant_a),
    .full      (a_full),
    .empty     (a_empty),
    .count     (a_count),
    .head      (a_head)
`ifdef WB_FWD_EN
    , .entries (a_ent)
`endif
  );

  wb_fifo #(.DEPTH(DEPTH)) u_fifo_b (
    .clk       (clk),
    .reset     (reset),
    .push      (b_push),
    .push_data (b_in),
    .pop       (grant_b),
    .full      (b_full),
    .empty     (b_empty),
    .count     (b_count),
    .head      (b_head)
`ifdef WB_FWD_EN
    , .entries (b_ent)
`endif
  );

  // Grant looks only at occupancy before this edge, so a push never falls through.
  assign grant_a = !a_empty && (b_empty || (rr_last == CH_B));
  assign grant_b = !b_empty && (a_empty || (rr_last == CH_A));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_we_q  <= 1'b0;
      wb_rw_q  <= '0;
      wb_din_q <= '0;
      rr_last  <= CH_B;
    end else if (grant_a) begin
      wb_we_q  <= 1'b1;
      wb_rw_q  <= a_head.rw;
      wb_din_q <= a_head.din;
      rr_last  <= CH_A;
    end else if (grant_b) begin
      wb_we_q  <= 1'b1;
      wb_rw_q  <= b_head.rw;
      wb_din_q <= b_head.din;
      rr_last  <= CH_B;
    end else begin
      wb_we_q  <= 1'b0;
    end
  end

  assign bus.wb_we  = wb_we_q;
  assign bus.wb_rw  = wb_rw_q;
  assign bus.wb_din = wb_din_q;
  assign bus.idle   = (a_count == '0) && (b_count == '0) && !wb_we_q;

`ifdef WB_FWD_EN
  // Scan lowest priority first so later (higher priority, newer) matches override.
  always_comb begin
    bus.fwd_hit  = 1'b0;
    bus.fwd_data = '0;
    if (!reset) begin
      if (wb_we_q && (wb_rw_q == bus.fwd_ra)) begin
        bus.fwd_hit  = 1'b1;
        bus.fwd_data = wb_din_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if ((CW'(i) < b_count) && (b_ent[i].rw == bus.fwd_ra)) begin
          bus.fwd_hit  = 1'b1;
          bus.fwd_data = b_ent[i].din;
        end
      end
      for (int i = 0; i < DEPTH; i++) begin
        if ((CW'(i) < a_count) && (a_ent[i].rw == bus.fwd_ra)) begin
          bus.fwd_hit  = 1'b1;
          bus.fwd_data = a_ent[i].din;
        end
      end
    end
  end
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: vector table, corner sequences, random traffic vs queue model.
// Forwarding checks are compiled in when WB_FWD_EN is defined.
module tb_regfile_wb_arbiter;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.AW(6), .DW(32)) bus ();

  regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: per-channel expected queues of {rw, din}, round-robin memory, output register.
  logic [37:0] exp_qa[$];
  logic [37:0] exp_qb[$];
  bit          m_last_b;
  logic        m_we;
  logic [5:0]  m_rw;
  logic [31:0] m_din;
  bit          last_a_acc, last_b_acc, last_b_rdy;
  logic [5:0]  cur_ra = 6'd0;

  typedef struct {
    bit          rst;
    bit          av;
    logic [5:0]  arw;
    logic [31:0] adin;
    bit          bv;
    logic [5:0]  brw;
    logic [31:0] bdin;
    logic        we;
    logic [5:0]  rw;
    logic [31:0] din;
  } vec_t;
  vec_t vt[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    exp_qa.delete();
    exp_qb.delete();
    m_last_b = 1'b1;
    m_we     = 1'b0;
    m_rw     = '0;
    m_din    = '0;
  endtask

`ifdef WB_FWD_EN
  // Highest priority first: A newest..oldest, B newest..oldest, then the output register.
  task automatic check_fwd();
    logic        h = 1'b0;
    logic [31:0] d = '0;
    for (int i = exp_qa.size() - 1; i >= 0 && !h; i--)
      if (exp_qa[i][37:32] == cur_ra) begin h = 1'b1; d = exp_qa[i][31:0]; end
    for (int i = exp_qb.size() - 1; i >= 0 && !h; i--)
      if (exp_qb[i][37:32] == cur_ra) begin h = 1'b1; d = exp_qb[i][31:0]; end
    if (!h && m_we && (m_rw == cur_ra)) begin h = 1'b1; d = m_din; end
    check("fwd_hit", bus.fwd_hit, h);
    check("fwd_data", bus.fwd_data, d);
  endtask
`endif

  // Drive one cycle of requests, check pre-edge readies, advance the model across the edge, check outputs.
  task automatic step(input bit av, input logic [5:0] arw, input logic [31:0] adin,
                      input bit bv, input logic [5:0] brw, input logic [31:0] bdin);
    bit ga, gb, ar, br;
    logic [37:0] e;
    bus.a_valid = av; bus.a_rw = arw; bus.a_din = adin;
    bus.b_valid = bv; bus.b_rw = brw; bus.b_din = bdin;
`ifdef WB_FWD_EN
    bus.fwd_ra = cur_ra;
`endif
    #1;
    ar = (exp_qa.size() != DEPTH);
    br = (exp_qb.size() != DEPTH);
    check("a_ready", bus.a_ready, ar);
    check("b_ready", bus.b_ready, br);
`ifdef WB_FWD_EN
    check_fwd();
`endif
    ga = (exp_qa.size() > 0) && ((exp_qb.size() == 0) || m_last_b);
    gb = (exp_qb.size() > 0) && !ga;
    last_a_acc = av && ar;
    last_b_acc = bv && br;
    last_b_rdy = br;
    @(posedge clk);
    #1;
    if (ga) begin
      e = exp_qa.pop_front(); m_we = 1'b1; m_rw = e[37:32]; m_din = e[31:0]; m_last_b = 1'b0;
    end else if (gb) begin
      e = exp_qb.pop_front(); m_we = 1'b1; m_rw = e[37:32]; m_din = e[31:0]; m_last_b = 1'b1;
    end else begin
      m_we = 1'b0;
    end
    if (last_a_acc) exp_qa.push_back({arw, adin});
    if (last_b_acc) exp_qb.push_back({brw, bdin});
    check("wb_we", bus.wb_we, m_we);
    check("wb_rw", bus.wb_rw, m_rw);
    check("wb_din", bus.wb_din, m_din);
    check("idle", bus.idle, (exp_qa.size() == 0) && (exp_qb.size() == 0) && !m_we);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_wb_we", bus.wb_we, 1'b0);
    check("rst_wb_rw", bus.wb_rw, 6'd0);
    check("rst_wb_din", bus.wb_din, 32'd0);
    check("rst_a_ready", bus.a_ready, 1'b0);
    check("rst_b_ready", bus.b_ready, 1'b0);
    check("rst_idle", bus.idle, 1'b1);
`ifdef WB_FWD_EN
    check("rst_fwd_hit", bus.fwd_hit, 1'b0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    reset_model();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(0, 6'd0, 32'd0, 0, 6'd0, 32'd0);
  endtask

  function automatic vec_t mk(bit rst, bit av, logic [5:0] arw, logic [31:0] adin,
                              bit bv, logic [5:0] brw, logic [31:0] bdin,
                              logic we, logic [5:0] rw, logic [31:0] din);
    vec_t v;
    v.rst = rst; v.av = av; v.arw = arw; v.adin = adin;
    v.bv = bv; v.brw = brw; v.bdin = bdin;
    v.we = we; v.rw = rw; v.din = din;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a_seq, b_seq;
    bit seen_b_full;
    bus.a_valid = 0; bus.a_rw = '0; bus.a_din = '0;
    bus.b_valid = 0; bus.b_rw = '0; bus.b_din = '0;
`ifdef WB_FWD_EN
    bus.fwd_ra = '0;
`endif

    // Single write latency, then interleaved dual-channel burst after a fresh reset.
    vt[0]  = mk(0, 1, 6'd5, 32'hDEADBEEF, 0, 6'd0, 32'd0,        0, 6'd0,  32'h0);
    vt[1]  = mk(0, 0, 6'd0, 32'd0,        0, 6'd0, 32'd0,        1, 6'd5,  32'hDEADBEEF);
    vt[2]  = mk(0, 0, 6'd0, 32'd0,        0, 6'd0, 32'd0,        0, 6'd5,  32'hDEADBEEF);
    vt[3]  = mk(1, 1, 6'd1, 32'hA0000001, 1, 6'd33, 32'hB0000021, 0, 6'd0,  32'h0);
    vt[4]  = mk(0, 1, 6'd2, 32'hA0000002, 1, 6'd34, 32'hB0000022, 1, 6'd1,  32'hA0000001);
    vt[5]  = mk(0, 1, 6'd3, 32'hA0000003, 1, 6'd35, 32'hB0000023, 1, 6'd33, 32'hB0000021);
    vt[6]  = mk(0, 1, 6'd4, 32'hA0000004, 1, 6'd36, 32'hB0000024, 1, 6'd2,  32'hA0000002);
    vt[7]  = mk(0, 0, 6'd0, 32'd0,        0, 6'd0, 32'd0,        1, 6'd34, 32'hB0000022);
    vt[8]  = mk(0, 0, 6'd0, 32'd0,        0, 6'd0, 32'd0,        1, 6'd3,  32'hA0000003);
    vt[9]  = mk(0, 0, 6'd0, 32'd0,        0, 6'd0, 32'd0,        1, 6'd35, 32'hB0000023);
    vt[10] = mk(0, 0, 6'd0, 32'd0,        0, 6'd0, 32'd0,        1, 6'd4,  32'hA0000004);
    vt[11] = mk(0, 0, 6'd0, 32'd0,        0, 6'd0, 32'd0,        1, 6'd36, 32'hB0000024);
    vt[12] = mk(0, 0, 6'd0, 32'd0,        0, 6'd0, 32'd0,        0, 6'd36, 32'hB0000024);

    do_reset();
    for (int i = 0; i < 13; i++) begin
      if (vt[i].rst) do_reset();
      step(vt[i].av, vt[i].arw, vt[i].adin, vt[i].bv, vt[i].brw, vt[i].bdin);
      check("vec_we", bus.wb_we, vt[i].we);
      check("vec_rw", bus.wb_rw, vt[i].rw);
      check("vec_din", bus.wb_din, vt[i].din);
    end

    // Saturate both channels: requests are held until accepted, data increments per channel.
    do_reset();
    a_seq = 32'h100; b_seq = 32'h200; seen_b_full = 0;
    for (int i = 0; i < 16; i++) begin
      step(1, 6'(a_seq & 7), a_seq, 1, 6'(32 + (b_seq & 7)), b_seq);
      if (last_a_acc) a_seq++;
      if (last_b_acc) b_seq++;
      if (!last_b_rdy) seen_b_full = 1;
    end
    check("b_full_seen", seen_b_full, 1'b1);
    idle_cycles(10);
    check("sat_drained_a", a_seq - 32'h100, 32'(exp_qa.size()) + (a_seq - 32'h100));
    check("sat_idle", bus.idle, 1'b1);

    // Asynchronous reset mid-cycle with entries pending and a write on the port.
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 6'(8 + i), 32'h300 + i, 1, 6'(40 + i), 32'h400 + i);
    check("pre_rst_pending", (exp_qa.size() + exp_qb.size()) >= 3, 1'b1);
    check("pre_rst_we", bus.wb_we, 1'b1);
    #2;
    do_reset();
    idle_cycles(3);
    step(1, 6'd0, 32'h55AA55AA, 0, 6'd0, 32'd0);
    step(0, 6'd0, 32'd0, 0, 6'd0, 32'd0);
    check("post_rst_r0_we", bus.wb_we, 1'b1);
    check("post_rst_r0_din", bus.wb_din, 32'h55AA55AA);
    idle_cycles(1);

`ifdef WB_FWD_EN
    // A pending write to r7 on channel A shadows an older one on channel B.
    do_reset();
    cur_ra = 6'd7;
    step(1, 6'd20, 32'h1, 1, 6'd7, 32'h11);
    step(1, 6'd7, 32'h22, 0, 6'd0, 32'd0);
    bus.a_valid = 0; bus.b_valid = 0;
    bus.fwd_ra = 6'd7;
    #1;
    check("fwd7_hit", bus.fwd_hit, 1'b1);
    check("fwd7_data", bus.fwd_data, 32'h22);
    idle_cycles(4);
    bus.fwd_ra = 6'd7;
    #1;
    check("fwd7_drained_hit", bus.fwd_hit, 1'b0);
    bus.fwd_ra = 6'd9;
    #1;
    check("fwd9_hit", bus.fwd_hit, 1'b0);
    check("fwd9_data", bus.fwd_data, 32'd0);
`endif

    // Random traffic against the model, with one reset in the middle.
    for (int c = 0; c < 300; c++) begin
      if (c == 150) do_reset();
      cur_ra = 6'($urandom_range(0, 15));
      step($urandom_range(0, 2) != 0, 6'($urandom_range(0, 15)), $urandom,
           $urandom_range(0, 2) != 0, 6'($urandom_range(0, 15)), $urandom);
    end
    idle_cycles(10);
    check("final_idle", bus.idle, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
